// File: rtl/ldpc_dvb_qpsk_llr_pack.sv
// QPSK soft-demap front end: quantises I/Q beats to LLRs and packs
// them into wide LDPC decoder words with frame framing and resync.
module ldpc_dvb_qpsk_llr_pack #(
  parameter int pIQ_W    = 16,
  parameter int pLLR_W   = 5,
  parameter int pSYM_NUM = 4,
  parameter int pLLR_NUM = 360
) (
  input  logic                         iclk,
  input  logic                         ireset,
  input  logic                         iclkena,
  input  logic                         isop,
  input  logic                         ival,
  input  logic                         ieop,
  input  logic [pSYM_NUM*pIQ_W-1:0]    idat_re,
  input  logic [pSYM_NUM*pIQ_W-1:0]    idat_im,
  output logic                         ordy,
  input  logic                         ireq,
  output logic                         osop,
  output logic                         oval,
  output logic                         oeop,
  output logic [pLLR_NUM*pLLR_W-1:0]   oLLR,
  output logic                         osync_err
);

  localparam int K  = pLLR_NUM / (2 * pSYM_NUM);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int BW = 2 * pSYM_NUM * pLLR_W;
  localparam int WW = pLLR_NUM * pLLR_W;
  localparam int SH = 12 - pLLR_W;
  localparam logic [CW-1:0] CLAST = CW'(K - 1);
  localparam logic signed [pIQ_W-1:0] SMAX = pIQ_W'(2047);
  localparam logic signed [pIQ_W-1:0] SMIN = -SMAX;

  // Symmetric clamp keeps the LLR range balanced around the reference point
  function automatic logic [pLLR_W-1:0] quant(input logic [pIQ_W-1:0] x);
    logic signed [pIQ_W-1:0] s;
    s = $signed(x);
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    return pLLR_W'(s >>> SH);
  endfunction

  logic [CW-1:0] c_q, c_d;
  logic [WW-1:0] buf_q, buf_d;
  logic [WW-1:0] llr_q, llr_d;
  logic          oval_q, oval_d;
  logic          osop_q, osop_d;
  logic          oeop_q, oeop_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;

  logic [BW-1:0] beat;
  logic [WW-1:0] word;
  logic [CW-1:0] slot;
  logic          accept;
  logic          xfer;
  logic          emit;

  assign ordy   = ireset & (~oval_q | ireq);
  assign accept = ival & ordy & iclkena;
  assign xfer   = oval_q & ireq & iclkena;

  always_comb begin
    beat = '0;
    for (int j = 0; j < pSYM_NUM; j++) begin
      beat[(2*j+1)*pLLR_W +: pLLR_W] = quant(idat_re[j*pIQ_W +: pIQ_W]);
      beat[(2*j)*pLLR_W +: pLLR_W]   = quant(idat_im[j*pIQ_W +: pIQ_W]);
    end
  end

  // A new word starts from zeros so short frames get erasure padding
  always_comb begin
    slot = isop ? '0 : c_q;
    word = (isop || c_q == '0) ? '0 : buf_q;
    word[int'(slot)*BW +: BW] = beat;
    emit = accept & ((slot == CLAST) | ieop);
  end

  always_comb begin
    c_d    = c_q;
    buf_d  = buf_q;
    llr_d  = llr_q;
    oval_d = oval_q;
    osop_d = osop_q;
    oeop_d = oeop_q;
    err_d  = err_q;
    pend_d = pend_q;
    if (iclkena) begin
      err_d = accept & isop & (c_q != '0);
      if (xfer) begin
        oval_d = 1'b0;
        osop_d = 1'b0;
        oeop_d = 1'b0;
      end
      if (emit) begin
        llr_d  = word;
        oval_d = 1'b1;
        osop_d = isop | pend_q;
        oeop_d = ieop;
        c_d    = '0;
        pend_d = 1'b0;
      end else if (accept) begin
        buf_d  = word;
        c_d    = slot + CW'(1);
        pend_d = pend_q | isop;
      end
    end
  end

  always_ff @(posedge iclk) begin
    buf_q <= buf_d;
    if (!ireset) begin
      c_q    <= '0;
      llr_q  <= '0;
      oval_q <= 1'b0;
      osop_q <= 1'b0;
      oeop_q <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      llr_q  <= llr_d;
      oval_q <= oval_d;
      osop_q <= osop_d;
      oeop_q <= oeop_d;
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  assign oval      = oval_q;
  assign osop      = osop_q;
  assign oeop      = oeop_q;
  assign oLLR      = llr_q;
  assign osync_err = err_q;

endmodule

// File: tb/tb_ldpc_dvb_qpsk_llr_pack.sv
// Scoreboard bench for the QPSK LLR packer: directed frames,
// backpressure, short frames, resync and mid-frame reset.
module tb_ldpc_dvb_qpsk_llr_pack;

  localparam int K  = 45;
  localparam int WW = 1800;

  logic          clk = 1'b0;
  logic          ireset, iclkena, isop, ival, ieop, ireq;
  logic [63:0]   idat_re, idat_im;
  logic          ordy, osop, oval, oeop, osync_err;
  logic [WW-1:0] oLLR;

  always #5 clk = ~clk;

  ldpc_dvb_qpsk_llr_pack dut (
    .iclk(clk), .ireset(ireset), .iclkena(iclkena),
    .isop(isop), .ival(ival), .ieop(ieop),
    .idat_re(idat_re), .idat_im(idat_im), .ordy(ordy),
    .ireq(ireq), .osop(osop), .oval(oval), .oeop(oeop),
    .oLLR(oLLR), .osync_err(osync_err)
  );

  typedef struct {
    logic [WW-1:0] w;
    bit            s;
    bit            e;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            errors = 0, checks = 0;
  int            exp_sync = 0, got_sync = 0;
  logic [WW-1:0] mw;
  int            mc = 0;
  bit            mpend = 0;
  logic [WW-1:0] held;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [WW-1:0] a,
                      input logic [WW-1:0] e);
    int n;
    checks++;
    if (a !== e) begin
      errors++;
      n = 0;
      for (int k = 0; k < 360; k++)
        if (a[k*5 +: 5] !== e[k*5 +: 5]) begin n = k; break; end
      $display("FAIL %s: LLR[%0d] got %0h expected %0h",
               nm, n, a[n*5 +: 5], e[n*5 +: 5]);
    end
  endtask

  function automatic int qm(input int xi);
    int x;
    x = xi;
    if (x > 2047) x = 2047;
    if (x < -2047) x = -2047;
    if (x >= 0) return x / 128;
    return -((-x + 127) / 128);
  endfunction

  function automatic logic [63:0] gre(input int seed);
    logic [63:0] r;
    int v;
    for (int j = 0; j < 4; j++) begin
      v = ((seed * 37 + j * 101) % 6001) - 3000;
      r[j*16 +: 16] = 16'(v);
    end
    return r;
  endfunction

  function automatic logic [63:0] gim(input int seed);
    logic [63:0] r;
    int v;
    for (int j = 0; j < 4; j++) begin
      v = ((seed * 53 + j * 71 + 11) % 6001) - 3000;
      r[j*16 +: 16] = 16'(v);
    end
    return r;
  endfunction

  task automatic model_beat(input bit s, input bit e,
                            input logic [63:0] re, input logic [63:0] im);
    exp_t x;
    int i;
    if (s && mc != 0) begin
      mc = 0;
      exp_sync++;
    end
    if (mc == 0) mw = '0;
    for (int j = 0; j < 4; j++) begin
      i = mc * 4 + j;
      mw[(2*i+1)*5 +: 5] = 5'(qm(int'($signed(re[j*16 +: 16]))));
      mw[(2*i)*5 +: 5]   = 5'(qm(int'($signed(im[j*16 +: 16]))));
    end
    if (mc == K - 1 || e) begin
      x.w = mw; x.s = s | mpend; x.e = e;
      sb.push_back(x);
      mc = 0;
      mpend = 0;
    end else begin
      mc++;
      mpend = mpend | s;
    end
  endtask

  task automatic send(input bit s, input bit e,
                      input logic [63:0] re, input logic [63:0] im);
    int n;
    n = 0;
    isop = s; ieop = e; idat_re = re; idat_im = im; ival = 1'b1;
    @(negedge clk);
    while (!ordy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ordy) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: ordy got 0 expected 1");
    end
    @(posedge clk);
    #1;
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  task automatic beat(input bit s, input bit e, input int seed);
    logic [63:0] re, im;
    re = gre(seed);
    im = gim(seed);
    send(s, e, re, im);
    model_beat(s, e, re, im);
  endtask

  task automatic frame(input int n, input bit s, input bit e,
                       input int seed);
    for (int b = 0; b < n; b++)
      beat(s && b == 0, e && b == n - 1, seed + b);
  endtask

  task automatic model_reset();
    mc = 0;
    mpend = 0;
  endtask

  always @(negedge clk) begin
    if (osync_err) got_sync++;
    if (ireset && oval && ireq) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got oval 1 expected 0");
      end else begin
        mon_e = sb.pop_front();
        chkw("word", oLLR, mon_e.w);
        chk("osop", 32'(osop), 32'(mon_e.s));
        chk("oeop", 32'(oeop), 32'(mon_e.e));
      end
    end
  end

  initial begin
    exp_t qx;
    ireset = 1'b0; iclkena = 1'b1; ival = 1'b0; isop = 1'b0;
    ieop = 1'b0; ireq = 1'b1; idat_re = '0; idat_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_oval", 32'(oval), 0);
    chk("rst_ordy", 32'(ordy), 0);
    chk("rst_osop", 32'(osop), 0);
    chk("rst_oeop", 32'(oeop), 0);
    chk("rst_err", 32'(osync_err), 0);
    chkw("rst_llr", oLLR, '0);
    @(posedge clk); #1;
    ireset = 1'b1;

    // quantisation: hand-computed one-beat frame
    qx.w = '0; qx.s = 1; qx.e = 1;
    qx.w[0*5 +: 5] = 5'd15;
    qx.w[1*5 +: 5] = 5'd8;
    qx.w[2*5 +: 5] = 5'b10000;
    qx.w[3*5 +: 5] = 5'b11000;
    qx.w[4*5 +: 5] = 5'd8;
    qx.w[7*5 +: 5] = 5'b11111;
    sb.push_back(qx);
    send(1, 1, {16'hFFFF, 16'h0000, 16'hFC00, 16'h0400},
               {16'h0000, 16'h0400, 16'hF448, 16'h0BB8});

    frame(45, 1, 1, 100);
    frame(10, 1, 1, 300);

    frame(20, 1, 0, 500);
    beat(1, 0, 600);
    @(negedge clk);
    chk("sync_pulse", 32'(osync_err), 1);
    @(negedge clk);
    chk("sync_clear", 32'(osync_err), 0);
    @(posedge clk); #1;
    frame(44, 0, 1, 620);

    @(negedge clk);
    @(posedge clk); #1;
    ireq = 1'b0;
    frame(45, 1, 1, 700);
    @(negedge clk);
    held = oLLR;
    chk("bp_oval", 32'(oval), 1);
    fork
      frame(45, 1, 1, 900);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_oval_hold", 32'(oval), 1);
          chk("bp_ordy", 32'(ordy), 0);
          chkw("bp_hold", oLLR, held);
        end
        @(posedge clk); #1;
        ireq = 1'b1;
        @(negedge clk);
        chk("bp_ordy_release", 32'(ordy), 1);
      end
    join

    frame(30, 1, 0, 1100);
    ireset = 1'b0;
    @(negedge clk);
    chk("rsta_ordy", 32'(ordy), 0);
    @(posedge clk); #1;
    ireset = 1'b1;
    model_reset();

    @(negedge clk);
    @(posedge clk); #1;
    ireq = 1'b0;
    frame(45, 1, 1, 1300);
    ireset = 1'b0;
    @(negedge clk);
    chk("rstb_ordy0", 32'(ordy), 0);
    chk("rstb_oval_pre", 32'(oval), 1);
    @(negedge clk);
    chk("rstb_oval", 32'(oval), 0);
    chk("rstb_ordy", 32'(ordy), 0);
    chkw("rstb_llr", oLLR, '0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    ireset = 1'b1;
    ireq = 1'b1;
    model_reset();

    frame(45, 0, 1, 1500);
    frame(45, 1, 1, 1700);

    for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(sb.size()), 0);
    chk("sync_count", 32'(got_sync), 32'(exp_sync));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldpc_dvb_qpsk_llr_pack.md
LDPC_DVB_QPSK_LLR_PACK -- requirements
Module: ldpc_dvb_qpsk_llr_pack

Interface
REQ-001 SHALL have parameter pIQ_W, default 16: signed I/Q sample width, ref point +-1024.
REQ-002 SHALL have parameter pLLR_W, default 5: output LLR width (sign + 4 bits).
REQ-003 SHALL have parameter pSYM_NUM, default 4: QPSK symbols per input beat.
REQ-004 SHALL have parameter pLLR_NUM, default 360: LLRs per output word; pLLR_NUM mod (2*pSYM_NUM) = 0; K = pLLR_NUM/(2*pSYM_NUM) beats per word.
REQ-005 SHALL have ports, clock and reset first:
 iclk  in  1  clock, rising edge.
 ireset  in  1  reset, synchronous, active-low.
 iclkena  in  1  clock enable; low = all state holds.
 isop  in  1  first beat of frame.
 ival  in  1  input beat valid.
 ieop  in  1  last beat of frame.
 idat_re  in  pSYM_NUM*pIQ_W  I samples, symbol j at [j*pIQ_W +: pIQ_W].
 idat_im  in  pSYM_NUM*pIQ_W  Q samples, same packing.
 ordy  out  1  input beat accepted when ival & ordy & iclkena.
 ireq  in  1  downstream accept; word transferred when oval & ireq & iclkena.
 osop  out  1  first word of frame.
 oval  out  1  output word valid.
 oeop  out  1  last word of frame.
 oLLR  out  pLLR_NUM*pLLR_W  LLRs, LLR n at [n*pLLR_W +: pLLR_W].
 osync_err  out  1  one-cycle pulse on framing error.

Function
REQ-006 SHALL compute each component q per sample x: s = clamp(x, -2047, +2047); q = s arithmetic-shifted right by (12-pLLR_W), i.e. s[11 : 12-pLLR_W].
REQ-007 SHALL place, for accepted beat at word slot c and symbol j, with i = c*pSYM_NUM + j: LLR[2*i+1] = q(re), LLR[2*i] = q(im).
REQ-008 SHALL hold slot counter c in 0..K-1, incremented per accepted beat; wrap to 0 after slot K-1.
REQ-009 SHALL assert ordy = ireset & (!oval | ireq), combinationally.
REQ-010 SHALL, on accepted beat with c = K-1, register the full word (accumulated slots + current beat) into oLLR, set oval = 1 on next cycle, and reset c to 0.
REQ-011 SHALL drive osop = 1 on the first output word after a beat with isop, else 0; oeop = 1 on the word containing the ieop beat.
REQ-012 SHALL keep oval, osop, oeop and oLLR stable while oval & !ireq; clear oval after transfer unless a new word is loaded the same cycle (back-to-back: full throughput, one word per K beats).
REQ-013 SHALL, on accepted beat with ieop and c < K-1, emit the partial word immediately with oeop = 1, unfilled LLRs = 0 (erasure), and reset c to 0.
REQ-014 SHALL, on accepted beat with isop while c != 0, discard the partial word, restart at slot 0 with the current beat, and pulse osync_err for one cycle.
REQ-015 SHALL treat isop & ieop on the same beat as a one-beat frame: word emitted with osop = oeop = 1, padding per REQ-013.
REQ-016 SHALL ignore isop/ieop/idat when beat not accepted; latency last accepted beat -> oval = 1 cycle.

Reset
REQ-017 SHALL, while ireset = 0 on a clock edge (regardless of iclkena), set c = 0, oval = 0, osop = 0, oeop = 0, osync_err = 0, oLLR = 0, clear pending-sop flag; ordy = 0 while ireset = 0.
REQ-018 SHALL discard any partial or undelivered word on reset mid-frame; first beat after reset requires isop to set osop.

Verification
REQ-019 Quantisation (pLLR_W=5): samples +1024, -1024, 0, -1, +3000, -3000 -> LLRs +8, -8, 0, -1, +15, -16.
REQ-020 Full frame, default params, ireq=1: 45 beats isop..ieop -> one word after beat 45, osop=oeop=1, LLR[1]=q(re sym0), LLR[0]=q(im sym0), LLR[359]=q(re sym179 of beat 45).
REQ-021 Backpressure: ireq=0 when word ready -> oval held, ordy=0, next beats stall with data unchanged; ireq=1 -> transfer, ordy=1 same cycle, no beats lost.
REQ-022 Short frame: ieop on beat 10 (c=9) -> word with oeop=1, LLR[80..359]=0.
REQ-023 Resync: isop on beat at c=20 -> osync_err pulse 1 cycle, following word built from new beats only.
REQ-024 Reset mid-frame: ireset=0 at c=30 with oval=1 -> next cycle oval=0, ordy=0; after release, fresh frame decoded correctly with osop=1.
